// File: rtl/cl_decode_pkg.sv
// Shared types and decode function for the decode stage.
// Instruction layout: {opcode[5:0], rd[4:0], rs[4:0], imm[15:0]}.
// Any opcode without a named constant below decodes to an all-zero control bundle.
package cl_decode_pkg;

    localparam int CL_DECODE_CNT_W = 32;

    // Opcode encodings.
    localparam logic [5:0] kADDU = 6'h01;
    localparam logic [5:0] kSUBU = 6'h02;
    localparam logic [5:0] kSLLV = 6'h03;
    localparam logic [5:0] kSRAV = 6'h04;
    localparam logic [5:0] kSRLV = 6'h05;
    localparam logic [5:0] kAND  = 6'h06;
    localparam logic [5:0] kOR   = 6'h07;
    localparam logic [5:0] kNOR  = 6'h08;
    localparam logic [5:0] kSLT  = 6'h09;
    localparam logic [5:0] kSLTU = 6'h0A;
    localparam logic [5:0] kMOV  = 6'h0B;
    localparam logic [5:0] kJALR = 6'h0C;
    localparam logic [5:0] kLW   = 6'h0D;
    localparam logic [5:0] kLBU  = 6'h0E;
    localparam logic [5:0] kBLR  = 6'h0F;
    localparam logic [5:0] kXOR  = 6'h10;
    localparam logic [5:0] kROR  = 6'h11;
    localparam logic [5:0] kSW   = 6'h12;
    localparam logic [5:0] kSB   = 6'h13;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [15:0] imm;
    } instruction_s;

    typedef struct packed {
        logic is_load;
        logic writes_rf;
        logic is_store;
        logic is_mem;
        logic is_byte;
    } ctrl_s;

    function automatic ctrl_s decode_ctrl(input instruction_s instr);
        ctrl_s c;
        c           = '0;
        c.is_load   = instr.opcode inside {kLW, kLBU};
        c.is_store  = instr.opcode inside {kSW, kSB};
        c.is_mem    = c.is_load | c.is_store;
        c.is_byte   = instr.opcode inside {kLBU, kSB};
        c.writes_rf = instr.opcode inside {kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR,
                                           kNOR, kSLT, kSLTU, kMOV, kJALR, kLW, kLBU,
                                           kBLR, kXOR, kROR};
        return c;
    endfunction

endpackage

// File: rtl/cl_decode_ctrl.sv
// Combinational control-bundle decoder, used on the queue write side.
module cl_decode_ctrl
    import cl_decode_pkg::*;
(
    input  instruction_s instruction_i,
    output ctrl_s        ctrl_o
);

    assign ctrl_o = decode_ctrl(instruction_i);

endmodule

// File: rtl/cl_decode_stage.sv
// Registered decode stage: decodes fetched instructions and buffers them in a
// FIFO_DEPTH-entry queue with valid/ready on both sides and a flush on redirect.
// Optional feature macro: CL_DECODE_STATS_EN adds saturating counters of loads and
// stores consumed downstream; without it the counter outputs are tied to zero.
module cl_decode_stage
    import cl_decode_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int PC_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  instruction_s               instruction_i,
    input  logic [PC_WIDTH-1:0]        pc_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output instruction_s               instruction_o,
    output logic [PC_WIDTH-1:0]        pc_o,
    output ctrl_s                      ctrl_o,
    output logic [CL_DECODE_CNT_W-1:0] load_cnt_o,
    output logic [CL_DECODE_CNT_W-1:0] store_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    instruction_s        instr_mem_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
    ctrl_s               ctrl_mem_q  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic  full, empty, push, pop;
    ctrl_s wr_ctrl;

    cl_decode_ctrl u_ctrl (
        .instruction_i (instruction_i),
        .ctrl_o        (wr_ctrl)
    );

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign ready_o = ~full;
    assign valid_o = ~empty;
    // Flush cancels both sides of the handshake in the same cycle.
    assign push    = valid_i & ~full & ~flush_i;
    assign pop     = ~empty & ready_i & ~flush_i;

    assign instruction_o = instr_mem_q[rd_ptr_q];
    assign pc_o          = pc_mem_q[rd_ptr_q];
    assign ctrl_o        = ctrl_mem_q[rd_ptr_q];

    // Queue storage: write the decoded entry at the tail on push; no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= instruction_i;
            pc_mem_q[wr_ptr_q]    <= pc_i;
            ctrl_mem_q[wr_ptr_q]  <= wr_ctrl;
        end
    end

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef CL_DECODE_STATS_EN
    logic [CL_DECODE_CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CL_DECODE_CNT_W-1:0] store_cnt_q, store_cnt_d;

    // Count consumed loads/stores, saturating; flush does not clear them.
    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (pop && ctrl_o.is_load && (load_cnt_q != '1))
            load_cnt_d = load_cnt_q + CL_DECODE_CNT_W'(1);
        if (pop && ctrl_o.is_store && (store_cnt_q != '1))
            store_cnt_d = store_cnt_q + CL_DECODE_CNT_W'(1);
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
`else
    assign load_cnt_o  = '0;
    assign store_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cl_decode_stage.sv
// Testbench for cl_decode_stage (default FIFO_DEPTH=2, PC_WIDTH=16).
// Counter expectations follow CL_DECODE_STATS_EN when it is defined.
module tb_cl_decode_stage;
    import cl_decode_pkg::*;

    localparam int DEPTH = 2;
    localparam int PCW   = 16;
`ifdef CL_DECODE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk     = 1'b0;
    logic           n_reset = 1'b1;
    logic           flush_i = 1'b0;
    logic           valid_i = 1'b0;
    logic           ready_i = 1'b0;
    instruction_s   instruction_i = '0;
    logic [PCW-1:0] pc_i = '0;
    logic           ready_o, valid_o;
    instruction_s   instruction_o;
    logic [PCW-1:0] pc_o;
    ctrl_s          ctrl_o;
    logic [31:0]    load_cnt_o, store_cnt_o;

    cl_decode_stage #(.FIFO_DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .ctrl_o        (ctrl_o),
        .load_cnt_o    (load_cnt_o),
        .store_cnt_o   (store_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of accepted entries plus consumed-op tallies.
    typedef struct packed {
        instruction_s   ins;
        logic [PCW-1:0] pc;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_ld, m_st;
    int          pass_cnt, total_cnt;

    // Expected bundle {is_load, writes_rf, is_store, is_mem, is_byte} from the opcode lists.
    function automatic logic [4:0] ref_ctrl(input logic [5:0] op);
        logic ld, st, wrf, byt;
        ld  = (op == kLW) || (op == kLBU);
        st  = (op == kSW) || (op == kSB);
        byt = (op == kLBU) || (op == kSB);
        wrf = op inside {kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR, kSLT,
                         kSLTU, kMOV, kJALR, kLW, kLBU, kBLR, kXOR, kROR};
        return {ld, wrf, st, ld | st, byt};
    endfunction

    function automatic instruction_s mk(input logic [5:0] op);
        instruction_s i;
        i.opcode = op;
        i.rd     = 5'($urandom);
        i.rs     = 5'($urandom);
        i.imm    = 16'($urandom);
        return i;
    endfunction

    function automatic logic [31:0] exp_cnt(input int unsigned n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    // Apply one clock edge to the model using the currently driven inputs, then to the DUT.
    task automatic tick();
        bit         acc, pop;
        logic [4:0] c;
        acc = valid_i && (mq.size() < DEPTH) && !flush_i;
        pop = ready_i && (mq.size() != 0) && !flush_i;
        if (flush_i) begin
            mq.delete();
        end else begin
            if (pop) begin
                c = ref_ctrl(mq[0].ins.opcode);
                if (c[4]) m_ld++;
                if (c[2]) m_st++;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(ent_t'{ins: instruction_i, pc: pc_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        #2 n_reset = 1'b0;
        mq.delete(); m_ld = 0; m_st = 0;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if ({valid_o, ready_o, load_cnt_o, store_cnt_o} !== {1'b0, 1'b1, 64'd0})
                $display("FAIL reset_idle cyc=%0d got v=%b r=%b ld=%0d st=%0d want v=0 r=1 ld=0 st=0",
                         i, valid_o, ready_o, load_cnt_o, store_cnt_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_lbu();
        ready_i = 1'b1; valid_i = 1'b1;
        instruction_i = mk(kLBU); pc_i = 16'h0004;
        tick();
        valid_i = 1'b0;
        total_cnt++;
        if ({valid_o, pc_o, ctrl_o, instruction_o} !== {1'b1, 16'h0004, 5'b11011, instruction_i})
            $display("FAIL single_lbu got v=%b pc=%h ctrl=%b want v=1 pc=0004 ctrl=11011",
                     valid_o, pc_o, ctrl_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({valid_o, load_cnt_o} !== {1'b0, exp_cnt(1)})
            $display("FAIL single_lbu_pop got v=%b ld=%0d want v=0 ld=%0d",
                     valid_o, load_cnt_o, exp_cnt(1));
        else pass_cnt++;
        ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0; valid_i = 1'b1;
        instruction_i = mk(kSW); pc_i = 16'h0010;
        tick();
        total_cnt++;
        if ({ready_o, valid_o, instruction_o.opcode} !== {2'b11, kSW})
            $display("FAIL bp_first got r=%b v=%b op=%h want r=1 v=1 op=%h",
                     ready_o, valid_o, instruction_o.opcode, kSW);
        else pass_cnt++;
        instruction_i = mk(kADDU); pc_i = 16'h0014;
        tick();
        total_cnt++;
        if ({ready_o, valid_o, instruction_o.opcode} !== {2'b01, kSW})
            $display("FAIL bp_full got r=%b v=%b op=%h want r=0 v=1 op=%h",
                     ready_o, valid_o, instruction_o.opcode, kSW);
        else pass_cnt++;
        instruction_i = mk(kLW); pc_i = 16'h0018;
        tick();
        total_cnt++;
        if ({ready_o, instruction_o.opcode, pc_o} !== {1'b0, kSW, 16'h0010})
            $display("FAIL bp_held got r=%b op=%h pc=%h want r=0 op=%h pc=0010",
                     ready_o, instruction_o.opcode, pc_o, kSW);
        else pass_cnt++;
        ready_i = 1'b1;
        tick();
        total_cnt++;
        if ({ready_o, instruction_o.opcode, pc_o, ctrl_o} !== {1'b1, kADDU, 16'h0014, 5'b01000})
            $display("FAIL bp_drain1 got r=%b op=%h pc=%h ctrl=%b want r=1 op=%h pc=0014 ctrl=01000",
                     ready_o, instruction_o.opcode, pc_o, ctrl_o, kADDU);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({valid_o, instruction_o.opcode, pc_o, ctrl_o} !== {1'b1, kLW, 16'h0018, 5'b11010})
            $display("FAIL bp_drain2 got v=%b op=%h pc=%h ctrl=%b want v=1 op=%h pc=0018 ctrl=11010",
                     valid_o, instruction_o.opcode, pc_o, ctrl_o, kLW);
        else pass_cnt++;
        valid_i = 1'b0;
        tick();
        total_cnt++;
        if ({valid_o, ready_o, load_cnt_o, store_cnt_o} !== {2'b01, exp_cnt(m_ld), exp_cnt(m_st)})
            $display("FAIL bp_empty got v=%b r=%b ld=%0d st=%0d want v=0 r=1 ld=%0d st=%0d",
                     valid_o, ready_o, load_cnt_o, store_cnt_o, exp_cnt(m_ld), exp_cnt(m_st));
        else pass_cnt++;
        ready_i = 1'b0;
    endtask

    task automatic test_flush_full();
        ready_i = 1'b0; valid_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            instruction_i = mk(kSB); pc_i = 16'(16'h0100 + 4 * i);
            tick();
        end
        total_cnt++;
        if ({valid_o, ready_o} !== 2'b10)
            $display("FAIL flush_prefull got v=%b r=%b want v=1 r=0", valid_o, ready_o);
        else pass_cnt++;
        flush_i = 1'b1; ready_i = 1'b1;
        instruction_i = mk(kLW); pc_i = 16'hBEEF;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        total_cnt++;
        if ({valid_o, ready_o} !== 2'b01)
            $display("FAIL flush_empty got v=%b r=%b want v=0 r=1", valid_o, ready_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({valid_o, load_cnt_o, store_cnt_o} !== {1'b0, exp_cnt(m_ld), exp_cnt(m_st)})
            $display("FAIL flush_discard got v=%b ld=%0d st=%0d want v=0 ld=%0d st=%0d",
                     valid_o, load_cnt_o, store_cnt_o, exp_cnt(m_ld), exp_cnt(m_st));
        else pass_cnt++;
        ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[100];
        logic [5:0] alu[5];
        logic [5:0] t;
        int         j;
        do_reset();
        alu[0] = kADDU; alu[1] = kXOR; alu[2] = kAND; alu[3] = kSLT; alu[4] = 6'h00;
        for (int i = 0; i < 100; i++)
            ops[i] = (i < 40) ? kLW : (i < 50) ? kSB : alu[$urandom_range(0, 4)];
        for (int i = 99; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ops[i]; ops[i] = ops[j]; ops[j] = t;
        end
        ready_i = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            instruction_i = mk(ops[i]); pc_i = 16'(4 * i);
            tick();
            total_cnt++;
            if ({valid_o, ready_o, pc_o, ctrl_o} !== {2'b11, 16'(4 * i), ref_ctrl(ops[i])})
                $display("FAIL stream i=%0d got v=%b r=%b pc=%h ctrl=%b want v=1 r=1 pc=%h ctrl=%b",
                         i, valid_o, ready_o, pc_o, ctrl_o, 16'(4 * i), ref_ctrl(ops[i]));
            else pass_cnt++;
        end
        valid_i = 1'b0;
        tick();
        total_cnt++;
        if ({valid_o, load_cnt_o, store_cnt_o} !== {1'b0, exp_cnt(40), exp_cnt(10)})
            $display("FAIL stream_stats got v=%b ld=%0d st=%0d want v=0 ld=%0d st=%0d",
                     valid_o, load_cnt_o, store_cnt_o, exp_cnt(40), exp_cnt(10));
        else pass_cnt++;
        ready_i = 1'b0;
    endtask

    task automatic test_random();
        logic [1+1+PCW+$bits(instruction_s)+5-1:0] got, want;
        for (int i = 0; i < 400; i++) begin
            valid_i       = ($urandom_range(0, 3) != 0);
            ready_i       = ($urandom_range(0, 2) != 0);
            flush_i       = ($urandom_range(0, 19) == 0);
            instruction_i = mk(6'($urandom_range(0, 23)));
            pc_i          = 16'($urandom);
            tick();
            if (mq.size() != 0) begin
                want = {1'b1, mq.size() < DEPTH, mq[0].pc, mq[0].ins, ref_ctrl(mq[0].ins.opcode)};
                got  = {valid_o, ready_o, pc_o, instruction_o, ctrl_o};
            end else begin
                want = {2'b01, {(PCW + $bits(instruction_s) + 5){1'b0}}};
                got  = {valid_o, ready_o, {(PCW + $bits(instruction_s) + 5){1'b0}}};
            end
            total_cnt++;
            if (got !== want || load_cnt_o !== exp_cnt(m_ld) || store_cnt_o !== exp_cnt(m_st))
                $display("FAIL random i=%0d got %h ld=%0d st=%0d want %h ld=%0d st=%0d",
                         i, got, load_cnt_o, store_cnt_o, want, exp_cnt(m_ld), exp_cnt(m_st));
            else pass_cnt++;
        end
        valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset_midstream();
        ready_i = 1'b0; valid_i = 1'b1;
        instruction_i = mk(kLW); pc_i = 16'h0200;
        tick();
        valid_i = 1'b0;
        total_cnt++;
        if (valid_o !== 1'b1)
            $display("FAIL midrst_pre got v=%b want v=1", valid_o);
        else pass_cnt++;
        #2 n_reset = 1'b0;
        mq.delete(); m_ld = 0; m_st = 0;
        #1;
        total_cnt++;
        if ({valid_o, ready_o, load_cnt_o, store_cnt_o} !== {2'b01, 64'd0})
            $display("FAIL midrst_async got v=%b r=%b ld=%0d st=%0d want v=0 r=1 ld=0 st=0",
                     valid_o, ready_o, load_cnt_o, store_cnt_o);
        else pass_cnt++;
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b1; instruction_i = mk(kSB); pc_i = 16'h0300;
        tick();
        valid_i = 1'b0;
        total_cnt++;
        if ({valid_o, pc_o, ctrl_o} !== {1'b1, 16'h0300, 5'b00111})
            $display("FAIL midrst_resume got v=%b pc=%h ctrl=%b want v=1 pc=0300 ctrl=00111",
                     valid_o, pc_o, ctrl_o);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; m_ld = 0; m_st = 0;
        test_reset();
        test_single_lbu();
        test_backpressure();
        test_flush_full();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
